// File: rtl/voltage_bcd_converter_pkg.sv
// rtl/voltage_bcd_converter_pkg.sv - shared types and constants for the voltage BCD converter
// Purpose: FSM state encoding, BCD digit geometry and clamp value used by
//          voltage_bcd_converter and its double-dabble sub-module.
// Ports:   none (package).
package voltage_bcd_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    localparam int DIGIT_W   = 4;
    localparam int DIGIT_CNT = 4;
    localparam int BCD_W     = DIGIT_W * DIGIT_CNT;
    localparam int CODE_W    = 12;
    localparam int MV_W      = 14;
    localparam int DD_ITERS  = MV_W;

    localparam logic [MV_W-1:0] CLAMP_MV = 14'd9999;

endpackage

// File: rtl/voltage_bcd_converter_bin2bcd_dd.sv
// rtl/voltage_bcd_converter_bin2bcd_dd.sv - sequential 14-bit double-dabble binary to BCD
// Purpose: converts a 14-bit binary value (<= 9999) into 4 packed BCD digits,
//          one add-3/shift iteration per clock, 14 iterations per conversion.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   start  in   load bin and begin a conversion
//   bin    in   14-bit binary value, sampled when start=1
//   done   out  high during the final iteration; bcd is final from the next cycle
//   bcd    out  {thousands, hundreds, tens, units}
module bin2bcd_dd
    import voltage_bcd_converter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MV_W-1:0]  bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam logic [3:0] LAST_ITER = 4'(DD_ITERS - 1);

    logic [BCD_W-1:0] bcd_sr;
    logic [BCD_W-1:0] bcd_adj;
    logic [MV_W-1:0]  bin_sr;
    logic [3:0]       iter;
    logic             active;

    // Any nibble >= 5 would carry past 9 after the shift, so pre-correct it.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int d = 0; d < DIGIT_CNT; d++) begin
            if (bcd_sr[d*DIGIT_W +: DIGIT_W] >= 4'd5) begin
                bcd_adj[d*DIGIT_W +: DIGIT_W] = bcd_sr[d*DIGIT_W +: DIGIT_W] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= 1'b0;
            iter   <= '0;
            bcd_sr <= '0;
            bin_sr <= '0;
        end else if (start) begin
            active <= 1'b1;
            iter   <= '0;
            bcd_sr <= '0;
            bin_sr <= bin;
        end else if (active) begin
            bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[MV_W-1]};
            bin_sr <= {bin_sr[MV_W-2:0], 1'b0};
            iter   <= iter + 4'd1;
            if (iter == LAST_ITER) begin
                active <= 1'b0;
            end
        end
    end

    assign done = active && (iter == LAST_ITER);
    assign bcd  = bcd_sr;

endmodule

// File: rtl/voltage_bcd_converter.sv
// rtl/voltage_bcd_converter.sv - ADC code to millivolt BCD display stage
// Purpose: selects live or averaged ADC code, scales to mV, clamps at 9999 and
//          converts to BCD on a periodic refresh tick or on a display-mode change.
// Ports:
//   clk             in   system clock
//   rst_n           in   synchronous active-low reset
//   meas_value      in   12-bit live ADC code
//   acumul_value    in   14-bit accumulator output, [11:0] is the average
//   average_enable  in   selects the average and flags average mode
//   bcd_digits      out  {thousands, hundreds, tens, units}
//   bcd_valid       out  one-cycle pulse when bcd_digits updates
//   avg_mode        out  average_enable captured at launch
//   overflow        out  scaled value exceeded 9999 and was clamped
//   busy            out  conversion in progress
module voltage_bcd_converter
    import voltage_bcd_converter_pkg::*;
#(
    parameter int VREF_MV        = 4096,
    parameter int REFRESH_CYCLES = 5_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] meas_value,
    input  logic [MV_W-1:0]   acumul_value,
    input  logic              average_enable,
    output logic [BCD_W-1:0]  bcd_digits,
    output logic              bcd_valid,
    output logic              avg_mode,
    output logic              overflow,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [MV_W-1:0]  VREF     = MV_W'(VREF_MV);

    conv_state_t       state_q;
    conv_state_t       state_d;
    logic [CNT_W-1:0]  refresh_cnt;
    logic              pending;
    logic              avg_en_prev;
    logic [CODE_W-1:0] code_q;
    logic              avg_mode_q;
    logic              ovf_q;
    logic              tick;
    logic              mode_edge;
    logic              launch;
    logic [MV_W-1:0]   mv_raw;
    logic [CODE_W-1:0] frac_unused;
    logic [1:0]        acumul_hi_unused;
    logic              mv_over;
    logic [MV_W-1:0]   mv_clamped;
    logic              dd_done;
    logic [BCD_W-1:0]  dd_bcd;

    assign acumul_hi_unused = acumul_value[MV_W-1:CODE_W];

    assign tick      = (refresh_cnt == CNT_LAST);
    assign mode_edge = (average_enable != avg_en_prev);
    // A trigger seen in IDLE launches in the same cycle instead of waiting on pending.
    assign launch    = (state_q == ST_IDLE) && (pending || tick || mode_edge);
    assign busy      = (state_q != ST_IDLE);

    // mV = (code * VREF_MV) >> 12; the discarded fraction truncates toward zero.
    assign {mv_raw, frac_unused} = {{MV_W{1'b0}}, code_q} * {{CODE_W{1'b0}}, VREF};
    assign mv_over    = (mv_raw > CLAMP_MV);
    assign mv_clamped = mv_over ? CLAMP_MV : mv_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
        end else if (tick) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (launch) state_d = ST_SCALE;
            ST_SCALE: state_d = ST_SHIFT;
            ST_SHIFT: if (dd_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending     <= 1'b0;
            avg_en_prev <= 1'b0;
            code_q      <= '0;
            avg_mode_q  <= 1'b0;
            ovf_q       <= 1'b0;
            bcd_digits  <= '0;
            bcd_valid   <= 1'b0;
            avg_mode    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            avg_en_prev <= average_enable;
            bcd_valid   <= 1'b0;
            // While busy only one conversion can be queued: pending is a flag, not a count.
            if (launch) begin
                pending    <= 1'b0;
                code_q     <= average_enable ? acumul_value[CODE_W-1:0] : meas_value;
                avg_mode_q <= average_enable;
            end else if (tick || mode_edge) begin
                pending <= 1'b1;
            end
            if (state_q == ST_SCALE) begin
                ovf_q <= mv_over;
            end
            if (state_q == ST_DONE) begin
                bcd_digits <= dd_bcd;
                avg_mode   <= avg_mode_q;
                overflow   <= ovf_q;
                bcd_valid  <= 1'b1;
            end
        end
    end

    bin2bcd_dd u_bin2bcd_dd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (state_q == ST_SCALE),
        .bin   (mv_clamped),
        .done  (dd_done),
        .bcd   (dd_bcd)
    );

endmodule

// File: tb/tb_voltage_bcd_converter.sv
// tb/tb_voltage_bcd_converter.sv - self-checking bench for voltage_bcd_converter
module tb_voltage_bcd_converter;

    localparam int REFRESH = 32;
    localparam int NDUT    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] meas_value = '0;
    logic [13:0] acumul_value = '0;
    logic        average_enable = 1'b0;

    logic [15:0] bcd_o   [NDUT];
    logic        valid_o [NDUT];
    logic        avgm_o  [NDUT];
    logic        ovf_o   [NDUT];
    logic        busy_o  [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int V = (g == 0) ? 4096 : (g == 1) ? 3300 : 16000;
        voltage_bcd_converter #(
            .VREF_MV        (V),
            .REFRESH_CYCLES (REFRESH)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .meas_value     (meas_value),
            .acumul_value   (acumul_value),
            .average_enable (average_enable),
            .bcd_digits     (bcd_o[g]),
            .bcd_valid      (valid_o[g]),
            .avg_mode       (avgm_o[g]),
            .overflow       (ovf_o[g]),
            .busy           (busy_o[g])
        );
    end

    function automatic int vref_of(input int k);
        return (k == 0) ? 4096 : (k == 1) ? 3300 : 16000;
    endfunction

    function automatic int model_mv(input int code, input int vref);
        return (code * vref) / 4096;
    endfunction

    function automatic logic [15:0] model_bcd(input int code, input int vref);
        int mv;
        mv = model_mv(code, vref);
        if (mv > 9999) mv = 9999;
        return {4'(mv / 1000), 4'((mv / 100) % 10), 4'((mv / 10) % 10), 4'(mv % 10)};
    endfunction

    function automatic logic model_ovf(input int code, input int vref);
        return model_mv(code, vref) > 9999;
    endfunction

    // Counts negedges until bcd_valid is seen; lat = -1 when the bound expires.
    task automatic wait_valid(input int limit, output int lat);
        lat = -1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (valid_o[0] === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int lat;
        meas_value = 12'd2500;
        acumul_value = '0;
        average_enable = 1'b0;
        apply_reset();
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (bcd_o[k] !== 16'h0000 || valid_o[k] !== 1'b0 || ovf_o[k] !== 1'b0 ||
                busy_o[k] !== 1'b0 || avgm_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: bcd=%h valid=%b ovf=%b busy=%b avg=%b, required 0000/0/0/0/0",
                         k, bcd_o[k], valid_o[k], ovf_o[k], busy_o[k], avgm_o[k]);
            end
        end
        rst_n = 1'b1;
        wait_valid(80, lat);
        checks++;
        if (lat != REFRESH + 16) begin
            errors++;
            $display("FAIL reset_first_latency: got %0d, required %0d", lat, REFRESH + 16);
        end
        checks++;
        if (bcd_o[0] !== 16'h2500) begin
            errors++;
            $display("FAIL live_2500: got %h, required 2500", bcd_o[0]);
        end
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (bcd_o[k] !== model_bcd(2500, vref_of(k)) || avgm_o[k] !== 1'b0 ||
                ovf_o[k] !== model_ovf(2500, vref_of(k)) || valid_o[k] !== 1'b1) begin
                errors++;
                $display("FAIL first_result dut%0d: bcd=%h avg=%b ovf=%b valid=%b, required %h/0/%b/1",
                         k, bcd_o[k], avgm_o[k], ovf_o[k], valid_o[k],
                         model_bcd(2500, vref_of(k)), model_ovf(2500, vref_of(k)));
            end
        end
        @(negedge clk);
        checks++;
        if (valid_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL valid_width: bcd_valid=%b one cycle after pulse, required 0", valid_o[0]);
        end
    endtask

    task automatic test_live();
        int codes[$];
        int lat;
        int prev;
        codes = {0, 4095, 2048, 1000};
        for (int i = 0; i < 8; i++) codes.push_back(int'($urandom_range(0, 4095)));
        meas_value = 12'd2500;
        average_enable = 1'b0;
        apply_reset();
        rst_n = 1'b1;
        wait_valid(80, lat);
        prev = 2500;
        foreach (codes[i]) begin
            meas_value = 12'(codes[i]);
            repeat (10) @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (bcd_o[k] !== model_bcd(prev, vref_of(k))) begin
                    errors++;
                    $display("FAIL hold dut%0d: bcd=%h, required %h", k, bcd_o[k], model_bcd(prev, vref_of(k)));
                end
            end
            wait_valid(40, lat);
            checks++;
            if (lat != REFRESH - 10) begin
                errors++;
                $display("FAIL refresh_period code=%0d: latency %0d, required %0d", codes[i], lat, REFRESH - 10);
            end
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (bcd_o[k] !== model_bcd(codes[i], vref_of(k)) || ovf_o[k] !== model_ovf(codes[i], vref_of(k)) ||
                    avgm_o[k] !== 1'b0 || valid_o[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL live dut%0d code=%0d: bcd=%h ovf=%b avg=%b valid=%b, required %h/%b/0/1",
                             k, codes[i], bcd_o[k], ovf_o[k], avgm_o[k], valid_o[k],
                             model_bcd(codes[i], vref_of(k)), model_ovf(codes[i], vref_of(k)));
                end
            end
            prev = codes[i];
        end
    endtask

    task automatic test_mode_change();
        int lat;
        meas_value = '0;
        acumul_value = '0;
        average_enable = 1'b0;
        apply_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        acumul_value = {2'b11, 12'd1234};
        average_enable = 1'b1;
        wait_valid(40, lat);
        checks++;
        if (lat != 17) begin
            errors++;
            $display("FAIL rise_latency: got %0d, required 17", lat);
        end
        checks++;
        if (bcd_o[0] !== 16'h1234 || avgm_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL rise_result: bcd=%h avg=%b, required 1234/1", bcd_o[0], avgm_o[0]);
        end
        wait_valid(40, lat);
        checks++;
        if (lat != 29) begin
            errors++;
            $display("FAIL tick_after_mode latency: got %0d, required 29", lat);
        end
        meas_value = 12'd7;
        acumul_value = 14'($urandom_range(0, 16383));
        average_enable = 1'b0;
        wait_valid(40, lat);
        checks++;
        if (lat != 17) begin
            errors++;
            $display("FAIL fall_latency: got %0d, required 17", lat);
        end
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (bcd_o[k] !== model_bcd(7, vref_of(k)) || avgm_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL fall_result dut%0d: bcd=%h avg=%b, required %h/0",
                         k, bcd_o[k], avgm_o[k], model_bcd(7, vref_of(k)));
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        int exp_t[4] = '{19, 36, 53, 80};
        int code_a;
        int code_b;
        code_a = int'($urandom_range(0, 4095));
        code_b = int'($urandom_range(0, 4095));
        meas_value = '0;
        average_enable = 1'b0;
        apply_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        acumul_value = 14'(code_a);
        average_enable = 1'b1;
        for (int t = 3; t <= 85; t++) begin
            @(negedge clk);
            if (valid_o[0] === 1'b1) begin
                pulses.push_back(t);
                if (pulses.size() <= 2) begin
                    for (int k = 0; k < NDUT; k++) begin
                        checks++;
                        if (bcd_o[k] !== model_bcd((pulses.size() == 1) ? code_a : code_b, vref_of(k)) ||
                            avgm_o[k] !== (pulses.size() == 1)) begin
                            errors++;
                            $display("FAIL collision_result%0d dut%0d: bcd=%h avg=%b, required %h/%b",
                                     pulses.size(), k, bcd_o[k], avgm_o[k],
                                     model_bcd((pulses.size() == 1) ? code_a : code_b, vref_of(k)),
                                     pulses.size() == 1);
                        end
                    end
                end
            end
            if (t == 8) begin
                average_enable = 1'b0;
                meas_value = 12'(code_b);
                acumul_value = 14'($urandom_range(0, 16383));
            end
        end
        checks++;
        if (pulses.size() != 4) begin
            errors++;
            $display("FAIL collision_pulse_count: got %0d, required 4", pulses.size());
        end
        for (int i = 0; i < 4 && i < pulses.size(); i++) begin
            checks++;
            if (pulses[i] != exp_t[i]) begin
                errors++;
                $display("FAIL collision_pulse_time%0d: got %0d, required %0d", i, pulses[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        meas_value = 12'($urandom_range(0, 4095));
        average_enable = 1'b0;
        apply_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        acumul_value = 14'($urandom_range(1, 4095));
        average_enable = 1'b1;
        repeat (4) @(negedge clk);
        average_enable = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (busy_o[k] !== 1'b0 || bcd_o[k] !== 16'h0000 || valid_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid dut%0d: busy=%b bcd=%h valid=%b, required 0/0000/0",
                         k, busy_o[k], bcd_o[k], valid_o[k]);
            end
        end
        rst_n = 1'b1;
        wait_valid(80, lat);
        checks++;
        if (lat != REFRESH + 16) begin
            errors++;
            $display("FAIL reset_mid_pending: next pulse after %0d, required %0d", lat, REFRESH + 16);
        end
    endtask

    initial begin
        test_reset();
        test_live();
        test_mode_change();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
